// File: rtl/apb_posted_bridge.sv
// APB-to-APB bridge with a DEPTH-entry posted-write FIFO; reads wait for the FIFO to drain.
// Optional access timeout: define APB_POSTED_TIMEOUT_EN to abort transfers stuck in ACCESS.
module apb_posted_bridge #(
    parameter int DW    = 32,
    parameter int AW    = 16,
    parameter int DEPTH = 4,
    parameter int TW    = 8
) (
    input  logic                        APB_CLK,
    input  logic                        APB_RESETN,
    input  logic                        APBS_PSEL,
    input  logic                        APBS_PENABLE,
    input  logic                        APBS_PWRITE,
    input  logic [AW-1:0]               APBS_PADDR,
    input  logic [DW-1:0]               APBS_PWDATA,
    output logic [DW-1:0]               APBS_PRDATA,
    output logic                        APBS_PREADY,
    output logic                        APBS_PSLVERR,
    output logic                        APBM_PSEL,
    output logic                        APBM_PENABLE,
    output logic                        APBM_PWRITE,
    output logic [AW-1:0]               APBM_PADDR,
    output logic [DW-1:0]               APBM_PWDATA,
    input  logic [DW-1:0]               APBM_PRDATA,
    input  logic                        APBM_PREADY,
    input  logic                        APBM_PSLVERR,
    output logic                        WERR,
    input  logic                        WERR_CLR,
    output logic [$clog2(DEPTH):0]      LEVEL,
    output logic                        IDLE
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t        r_state;
    logic [AW-1:0] r_buf_addr [DEPTH];
    logic [DW-1:0] r_buf_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_m_psel;
    logic          r_m_penable;
    logic          r_m_pwrite;
    logic [AW-1:0] r_m_paddr;
    logic [DW-1:0] r_m_pwdata;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_err;
    logic          r_werr;

    logic          w_full;
    logic          w_push;
    logic          w_read_launch;
    logic          w_tmo_abort;
    logic          w_done;
    logic          w_pop;
    logic          w_xfer_err;
    logic [PW-1:0] w_next_rptr;

    assign w_full        = (r_level == LW'(DEPTH));
    assign w_push        = APBS_PSEL & APBS_PENABLE & APBS_PWRITE & ~w_full;
    assign w_read_launch = APBS_PSEL & APBS_PENABLE & ~APBS_PWRITE & (r_level == '0);
    assign w_done        = (r_state == S_ACCESS) & (APBM_PREADY | w_tmo_abort);
    assign w_pop         = w_done & r_m_pwrite;
    assign w_xfer_err    = APBM_PSLVERR | w_tmo_abort;
    assign w_next_rptr   = r_rptr + 1'b1;

`ifdef APB_POSTED_TIMEOUT_EN
    logic [TW-1:0] r_tmo;

    // Counts ACCESS cycles starting at 1; hitting all-ones without PREADY aborts.
    always_ff @(posedge APB_CLK or negedge APB_RESETN) begin
        if (!APB_RESETN) begin
            r_tmo <= '0;
        end else if (r_state == S_SETUP) begin
            r_tmo <= TW'(1);
        end else if (r_state == S_ACCESS && !APBM_PREADY) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo_abort = (r_state == S_ACCESS) & ~APBM_PREADY & (r_tmo == '1);
`else
    logic [TW-1:0] w_tmo_unused;
    assign w_tmo_unused = '0;
    assign w_tmo_abort  = 1'b0;
`endif

    // Buffer storage carries no reset: contents are only meaningful between the pointers.
    always_ff @(posedge APB_CLK) begin
        if (w_push) begin
            r_buf_addr[r_wptr] <= APBS_PADDR;
            r_buf_data[r_wptr] <= APBS_PWDATA;
        end
    end

    always_ff @(posedge APB_CLK or negedge APB_RESETN) begin
        if (!APB_RESETN) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_m_psel    <= 1'b0;
            r_m_penable <= 1'b0;
            r_m_pwrite  <= 1'b0;
            r_m_paddr   <= '0;
            r_m_pwdata  <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_werr      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= w_next_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            if (w_pop && w_xfer_err) begin
                r_werr <= 1'b1;
            end else if (WERR_CLR) begin
                r_werr <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_level != '0) begin
                        r_state     <= S_SETUP;
                        r_m_psel    <= 1'b1;
                        r_m_penable <= 1'b0;
                        r_m_pwrite  <= 1'b1;
                        r_m_paddr   <= r_buf_addr[r_rptr];
                        r_m_pwdata  <= r_buf_data[r_rptr];
                    end else if (w_read_launch) begin
                        r_state     <= S_SETUP;
                        r_m_psel    <= 1'b1;
                        r_m_penable <= 1'b0;
                        r_m_pwrite  <= 1'b0;
                        r_m_paddr   <= APBS_PADDR;
                        r_m_pwdata  <= '0;
                    end
                end
                S_SETUP: begin
                    r_state     <= S_ACCESS;
                    r_m_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (w_done) begin
                        if (r_m_pwrite) begin
                            // Head entry is still counted, so >1 means another write is queued.
                            if (r_level > LW'(1)) begin
                                r_state     <= S_SETUP;
                                r_m_penable <= 1'b0;
                                r_m_paddr   <= r_buf_addr[w_next_rptr];
                                r_m_pwdata  <= r_buf_data[w_next_rptr];
                            end else begin
                                r_state     <= S_IDLE;
                                r_m_psel    <= 1'b0;
                                r_m_penable <= 1'b0;
                            end
                        end else begin
                            r_state     <= S_RESP;
                            r_m_psel    <= 1'b0;
                            r_m_penable <= 1'b0;
                            r_rsp_data  <= w_tmo_abort ? '0 : APBM_PRDATA;
                            r_rsp_err   <= w_xfer_err;
                        end
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_rsp_err <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign APBS_PREADY  = w_push | (r_state == S_RESP);
    assign APBS_PSLVERR = r_rsp_err;
    assign APBS_PRDATA  = r_rsp_data;
    assign APBM_PSEL    = r_m_psel;
    assign APBM_PENABLE = r_m_penable;
    assign APBM_PWRITE  = r_m_pwrite;
    assign APBM_PADDR   = r_m_paddr;
    assign APBM_PWDATA  = r_m_pwdata;
    assign WERR         = r_werr;
    assign LEVEL        = r_level;
    assign IDLE         = (r_state == S_IDLE) & (r_level == '0);

endmodule

// File: tb/tb_apb_posted_bridge.sv
// Scoreboard bench for apb_posted_bridge: expected slave responses and master transfers are
// queued at issue time and popped by negedge monitors as the DUT completes them.
module tb_apb_posted_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_psel = 1'b0, s_penable = 1'b0, s_pwrite = 1'b0;
    logic [15:0] s_paddr = '0;
    logic [31:0] s_pwdata = '0;
    logic [31:0] s_prdata;
    logic        s_pready, s_pslverr;
    logic        m_psel, m_penable, m_pwrite;
    logic [15:0] m_paddr;
    logic [31:0] m_pwdata;
    logic [31:0] m_prdata;
    logic        m_pready, m_pslverr;
    logic        werr;
    logic        werr_clr = 1'b0;
    logic [2:0]  level;
    logic        idle;

    logic        tgt_ready = 1'b1;
    logic [31:0] tgt_rdata = '0;
    int          err_at = -1;
    int          m_cnt = 0;
    int          cyc = 0;
    int          lvl_max = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct { logic wr; logic [15:0] addr; logic [31:0] data; } mexp_t;
    typedef struct { logic is_rd; logic [31:0] rdata; logic err; } sexp_t;
    mexp_t m_q[$];
    sexp_t s_q[$];
    int    done_cyc[$];

    apb_posted_bridge #(.DW(32), .AW(16), .DEPTH(4), .TW(4)) dut (
        .APB_CLK(clk), .APB_RESETN(rst_n),
        .APBS_PSEL(s_psel), .APBS_PENABLE(s_penable), .APBS_PWRITE(s_pwrite),
        .APBS_PADDR(s_paddr), .APBS_PWDATA(s_pwdata), .APBS_PRDATA(s_prdata),
        .APBS_PREADY(s_pready), .APBS_PSLVERR(s_pslverr),
        .APBM_PSEL(m_psel), .APBM_PENABLE(m_penable), .APBM_PWRITE(m_pwrite),
        .APBM_PADDR(m_paddr), .APBM_PWDATA(m_pwdata), .APBM_PRDATA(m_prdata),
        .APBM_PREADY(m_pready), .APBM_PSLVERR(m_pslverr),
        .WERR(werr), .WERR_CLR(werr_clr), .LEVEL(level), .IDLE(idle)
    );

    always #5 clk = ~clk;

    // Target model: zero-wait unless tgt_ready is held low; errors on transfer number err_at.
    assign m_pready  = tgt_ready;
    assign m_prdata  = tgt_rdata;
    assign m_pslverr = m_psel & m_penable & (m_cnt == err_at);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_psel && m_penable && m_pready) m_cnt <= m_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    logic [15:0] su_addr;
    logic [31:0] su_data;
    logic        su_wr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(level) > lvl_max) lvl_max = int'(level);
            if (m_psel && !m_penable) begin
                su_addr = m_paddr; su_data = m_pwdata; su_wr = m_pwrite;
            end
            if (m_psel && m_penable && m_pready) begin
                if (m_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL m_unexpected: got master %s addr 0x%0h, expected none",
                             m_pwrite ? "write" : "read", m_paddr);
                end else begin
                    mexp_t e;
                    e = m_q.pop_front();
                    chk("m_pwrite", 64'(m_pwrite), 64'(e.wr));
                    chk("m_paddr", 64'(m_paddr), 64'(e.addr));
                    if (e.wr) chk("m_pwdata", 64'(m_pwdata), 64'(e.data));
                    chk("m_stable", 64'({m_paddr, m_pwdata, m_pwrite}), 64'({su_addr, su_data, su_wr}));
                    $display("master %s addr=0x%0h data=0x%0h cycle=%0d", m_pwrite ? "WR" : "RD",
                             m_paddr, m_pwrite ? m_pwdata : m_prdata, cyc);
                    done_cyc.push_back(cyc);
                end
            end
            if (s_psel && s_penable && s_pready) begin
                if (s_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL s_unexpected: got slave completion addr 0x%0h, expected none", s_paddr);
                end else begin
                    sexp_t e;
                    e = s_q.pop_front();
                    chk("s_pslverr", 64'(s_pslverr), 64'(e.err));
                    if (e.is_rd) chk("s_prdata", 64'(s_prdata), 64'(e.rdata));
                    $display("slave %s addr=0x%0h rdata=0x%0h err=%0b cycle=%0d", s_pwrite ? "WR" : "RD",
                             s_paddr, s_prdata, s_pslverr, cyc);
                end
            end
        end
    end

    // Called at posedge+1; leaves the bus in SETUP of a following call or idle.
    task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                            output int waits);
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr; s_paddr = addr; s_pwdata = wdata;
        @(posedge clk); #1;
        s_penable = 1'b1;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (s_pready) break;
            waits++;
            if (waits >= 300) begin
                n_chk++;
                $display("FAIL s_timeout: got no PREADY for addr 0x%0h, expected completion", addr);
                break;
            end
        end
        @(posedge clk); #1;
        s_psel = 1'b0; s_penable = 1'b0;
    endtask

    task automatic wr_exp(input logic [15:0] addr, input logic [31:0] data, input logic to_master);
        sexp_t se;
        mexp_t me;
        se.is_rd = 1'b0; se.rdata = '0; se.err = 1'b0;
        s_q.push_back(se);
        if (to_master) begin
            me.wr = 1'b1; me.addr = addr; me.data = data;
            m_q.push_back(me);
        end
    endtask

    task automatic rd_exp(input logic [15:0] addr, input logic [31:0] rdata, input logic err,
                          input logic to_master);
        sexp_t se;
        mexp_t me;
        se.is_rd = 1'b1; se.rdata = rdata; se.err = err;
        s_q.push_back(se);
        if (to_master) begin
            me.wr = 1'b0; me.addr = addr; me.data = '0;
            m_q.push_back(me);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (idle) break;
        end
        chk(name, 64'(idle), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, w5, cnt_before;
        logic [15:0] a;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_psel", 64'(m_psel), 64'd0);
        chk("rst_m_penable", 64'(m_penable), 64'd0);
        chk("rst_m_paddr", 64'({m_pwrite, m_paddr, m_pwdata}), 64'd0);
        chk("rst_s_out", 64'({s_prdata, s_pslverr}), 64'd0);
        chk("rst_werr", 64'(werr), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: four posted writes, zero-wait target
        lvl_max = 0;
        done_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            a = 16'h0010 + 16'(4 * i);
            wr_exp(a, 32'hA0 + 32'(i), 1'b1);
            apb_xfer(1'b1, a, 32'hA0 + 32'(i), w);
            chk("t1_wr_waits", 64'(w), 64'd0);
        end
        wait_idle("t1_idle", 50);
        chk("t1_level", 64'(level), 64'd0);
        chk("t1_level_peak", 64'(lvl_max), 64'd2);
        chk("t1_xfer_count", 64'(done_cyc.size()), 64'd4);
        for (int i = 1; i < done_cyc.size(); i++)
            chk("t1_drain_gap", 64'(done_cyc[i] - done_cyc[i-1]), 64'd2);

        // T2: target stalled, fifth write waits for space
        tgt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 16'h0100 + 16'(4 * i);
            wr_exp(a, 32'hB0 + 32'(i), 1'b1);
            apb_xfer(1'b1, a, 32'hB0 + 32'(i), w);
            chk("t2_wr_waits", 64'(w), 64'd0);
        end
        wr_exp(16'h0110, 32'hB4, 1'b1);
        fork
            begin
                apb_xfer(1'b1, 16'h0110, 32'hB4, w5);
                chk("t2_w5_stalled", 64'(w5 >= 5), 64'd1);
            end
            begin
                repeat (6) @(negedge clk);
                chk("t2_full_pready", 64'(s_pready), 64'd0);
                chk("t2_full_level", 64'(level), 64'd4);
                @(posedge clk); #1;
                tgt_ready = 1'b1;
            end
        join
        wait_idle("t2_idle", 100);

        // T3: read ordered behind three buffered writes
        tgt_ready = 1'b0;
        tgt_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            a = 16'h0020 + 16'(4 * i);
            wr_exp(a, 32'hC0 + 32'(i), 1'b1);
            apb_xfer(1'b1, a, 32'hC0 + 32'(i), w);
        end
        rd_exp(16'h0040, 32'hDEADBEEF, 1'b0, 1'b1);
        fork
            apb_xfer(1'b0, 16'h0040, 32'h0, w);
            begin
                repeat (4) @(negedge clk);
                chk("t3_read_held_level", 64'(level), 64'd3);
                chk("t3_read_held_pwrite", 64'(m_pwrite), 64'd1);
                @(posedge clk); #1;
                tgt_ready = 1'b1;
            end
        join
        wait_idle("t3_idle", 50);
        tgt_rdata = 32'h12345678;
        rd_exp(16'h0044, 32'h12345678, 1'b0, 1'b1);
        apb_xfer(1'b0, 16'h0044, 32'h0, w);
        chk("t3_read_latency", 64'(w), 64'd3);

        // T4: error on second of three drained writes
        err_at = m_cnt + 1;
        for (int i = 0; i < 3; i++) begin
            a = 16'h0030 + 16'(4 * i);
            wr_exp(a, 32'hD0 + 32'(i), 1'b1);
            apb_xfer(1'b1, a, 32'hD0 + 32'(i), w);
        end
        wait_idle("t4_idle", 50);
        err_at = -1;
        chk("t4_werr_set", 64'(werr), 64'd1);
        repeat (3) @(negedge clk);
        chk("t4_werr_sticky", 64'(werr), 64'd1);
        @(posedge clk); #1;
        werr_clr = 1'b1;
        @(posedge clk); #1;
        werr_clr = 1'b0;
        @(negedge clk);
        chk("t4_werr_clr", 64'(werr), 64'd0);
        @(posedge clk); #1;
        err_at = m_cnt;
        wr_exp(16'h003C, 32'hD3, 1'b1);
        fork
            apb_xfer(1'b1, 16'h003C, 32'hD3, w);
            begin
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (m_psel && m_penable && m_pready) break;
                end
                werr_clr = 1'b1;
                @(posedge clk); #1;
                werr_clr = 1'b0;
                @(negedge clk);
                chk("t4_set_wins", 64'(werr), 64'd1);
            end
        join
        err_at = -1;
        wait_idle("t4_idle2", 50);
        werr_clr = 1'b1;
        @(posedge clk); #1;
        werr_clr = 1'b0;

`ifdef APB_POSTED_TIMEOUT_EN
        // T5: read timeout, target never ready
        tgt_ready = 1'b0;
        rd_exp(16'h0050, 32'h0, 1'b1, 1'b0);
        apb_xfer(1'b0, 16'h0050, 32'h0, w);
        chk("t5_timeout_waits", 64'(w), 64'd17);
        chk("t5_m_psel_dropped", 64'(m_psel), 64'd0);
        tgt_ready = 1'b1;
        wait_idle("t5_idle", 20);
`endif

        // T6: asynchronous reset with writes buffered and one mid-ACCESS
        tgt_ready = 1'b0;
        wr_exp(16'h0060, 32'hE0, 1'b0);
        apb_xfer(1'b1, 16'h0060, 32'hE0, w);
        wr_exp(16'h0064, 32'hE1, 1'b0);
        apb_xfer(1'b1, 16'h0064, 32'hE1, w);
        @(negedge clk);
        chk("t6_pre_access", 64'({m_psel, m_penable}), 64'b11);
        chk("t6_pre_level", 64'(level), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_psel", 64'({m_psel, m_penable}), 64'd0);
        chk("t6_rst_level", 64'(level), 64'd0);
        chk("t6_rst_idle", 64'(idle), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        cnt_before = m_cnt;
        tgt_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_no_stale", 64'(m_cnt), 64'(cnt_before));
        chk("t6_level_after", 64'(level), 64'd0);

        chk("end_m_q_empty", 64'(m_q.size()), 64'd0);
        chk("end_s_q_empty", 64'(s_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/apb_posted_bridge.md
# apb_posted_bridge

Single-clock APB-to-APB bridge with a parametrised posted-write buffer, for placement between an APB interconnect and slow peripheral targets. Writes complete on the slave port in zero wait states while buffer space exists and drain to the master port in order. Reads are strictly ordered behind all buffered writes. Write errors from the target are reported through a sticky status flag, because a posted write has already completed with PSLVERR=0.

## Interface
- DW, 32, data width
- AW, 16, address width
- DEPTH, 4, posted-write buffer entries; power of two, ≥2
- TW, 8, timeout counter width (used only with the timeout feature)

- APB_CLK  in  1  bridge clock, both ports
- APB_RESETN  in  1  asynchronous, active-low reset
- APBS_PSEL, APBS_PENABLE, APBS_PWRITE  in  1  slave-port control
- APBS_PADDR  in  AW  slave address
- APBS_PWDATA  in  DW  slave write data
- APBS_PRDATA  out  DW  read data
- APBS_PREADY  out  1  slave ready
- APBS_PSLVERR  out  1  slave error
- APBM_PSEL, APBM_PENABLE, APBM_PWRITE  out  1  master-port control
- APBM_PADDR  out  AW  master address
- APBM_PWDATA  out  DW  master write data
- APBM_PRDATA  in  DW  target read data
- APBM_PREADY, APBM_PSLVERR  in  1  target response
- WERR  out  1  sticky posted-write error
- WERR_CLR  in  1  clears WERR
- LEVEL  out  $clog2(DEPTH)+1  buffered-write count
- IDLE  out  1  buffer empty and master FSM in IDLE (write fence)

## Operation
- Reset values: all APBM_* outputs 0; APBS_PRDATA 0; APBS_PSLVERR 0; WERR 0; LEVEL 0; IDLE 1; FSM state IDLE; buffer pointers 0.
- Buffer: circular FIFO of {PADDR, PWDATA}. Pointers wrap modulo DEPTH. full = (LEVEL==DEPTH), evaluated on the registered count.
- Slave write, access phase (PSEL & PENABLE & PWRITE):
  - If !full: APBS_PREADY=1 and APBS_PSLVERR=0 combinationally, and the entry is pushed at this clock edge.
  - If full: APBS_PREADY=0. There is no push even if a pop happens in the same cycle; the write is accepted in the following cycle.
- Slave read, access phase: APBS_PREADY stays 0 until the read completes on the master port. A read is launched only when LEVEL==0 and the master FSM is in IDLE.
- Master FSM:
  - IDLE → SETUP when a write is pending or a read is launchable. Writes take priority, which is inherent because reads wait for an empty buffer.
  - SETUP: APBM_PSEL=1, APBM_PENABLE=0, address/data/PWRITE registered → ACCESS.
  - ACCESS: APBM_PENABLE=1, held until APBM_PREADY.
    - Write done: pop; set WERR if APBM_PSLVERR; → SETUP if LEVEL>1, else IDLE.
    - Read done: capture APBM_PRDATA and APBM_PSLVERR into the slave response registers → RESP.
  - RESP: APBS_PREADY=1 with the registered PRDATA/PSLVERR → IDLE.
- APBM_PADDR, APBM_PWDATA and APBM_PWRITE are stable from SETUP through the end of ACCESS.
- WERR: a set and a WERR_CLR in the same cycle leave WERR=1 (set wins).
- An APBS_PENABLE deassertion mid-wait is a protocol violation; behaviour in that case is undefined.

## Timing
- Posted write: zero wait states when not full. Entry reaches APBM_PSEL no earlier than 1 cycle after the push.
- Back-to-back drain: 2 cycles per write with a zero-wait target. There are no IDLE gaps between buffered writes.
- Read, buffer empty, zero-wait target, slave access in cycle A: master SETUP A+1, ACCESS A+2, APBS_PREADY=1 in A+3.
- Read behind N buffered writes: add 2N cycles plus target wait states.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronously) and buffer contents are discarded.

## Configuration
- APB_POSTED_TIMEOUT_EN defined:
  - A TW-bit counter runs during ACCESS and restarts on each SETUP.
  - If the counter reaches 2^TW−1 without APBM_PREADY, the transfer is aborted. APBM_PSEL and APBM_PENABLE drop on the next cycle.
  - Aborted write: popped, WERR set. Aborted read: completes via RESP with PSLVERR=1 and PRDATA=0.
- APB_POSTED_TIMEOUT_EN undefined: no counter; ACCESS waits for APBM_PREADY indefinitely. TW is unused.

## Test plan
- Reset, then 4 writes (0x10..0x1C, data 0xA0..0xA3) to a zero-wait target, DEPTH=4 -> each slave write PREADY in its access cycle; master shows the same 4 transfers in order, 2 cycles each; LEVEL peaks at ≤4; IDLE=1 at end.
- Target PREADY held low, 5 writes issued -> first 4 complete immediately, 5th waits with APBS_PREADY=0; after target releases, all 5 appear in order.
- 3 buffered writes then a read of 0x40 (target returns 0xDEADBEEF) -> read issued on master only after the 3rd write completes; APBS_PRDATA=0xDEADBEEF, PSLVERR=0.
- Target returns PSLVERR on the 2nd of 3 writes -> all slave writes report PSLVERR=0; WERR=1 after the 2nd drain and stays 1 until WERR_CLR; WERR_CLR in the same cycle as a new error leaves WERR=1.
- With APB_POSTED_TIMEOUT_EN and TW=4, target never ready on a read -> abort after 15 ACCESS cycles; slave gets PREADY with PSLVERR=1, PRDATA=0.
- APB_RESETN pulsed low with 2 writes buffered and a transfer mid-ACCESS -> APBM_PSEL=0, LEVEL=0, IDLE=1 immediately; no stale write appears after reset release.
